// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the Otter program-counter unit.
//   pc_sel_t   : next-PC source select code driven by the control unit
//   pc_state_t : BOOT/RUN sequencing state
//   DEF_*      : default parameter values for pc_unit and pc_unit_if
package pc_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0;
    localparam int          DEF_INC       = 4;
    localparam int          DEF_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_JALR   = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JAL    = 3'd3,
        SEL_TRAP   = 3'd4,
        SEL_MRET   = 3'd5,
        SEL_RAS    = 3'd6,
        SEL_RSVD   = 3'd7   // decoded as SEQ
    } pc_sel_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control-side bundle for pc_unit.
//   master : control unit / testbench (drives enables, select, targets, call/ret)
//   slave  : pc_unit (drives fetch address, next/inc addresses, status, RAS view)
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic            pc_we;
    pc_sel_t         pc_sel;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] pc_count;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_next;
    logic            pc_valid;
    logic            misalign;
    logic [XLEN-1:0] ras_pred;
    logic            ras_valid;

    modport master (
        output pc_we, pc_sel, br_target, jal_target, jalr_target, mtvec, mepc,
               is_call, is_ret,
        input  pc_count, pc_inc, pc_next, pc_valid, misalign, ras_pred, ras_valid
    );

    modport slave (
        input  pc_we, pc_sel, br_target, jal_target, jalr_target, mtvec, mepc,
               is_call, is_ret,
        output pc_count, pc_inc, pc_next, pc_valid, misalign, ras_pred, ras_valid
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst : clock, async active-high reset (clears pointer and count only)
//   push     : write din as the new top
//   pop      : drop the top entry (ignored when empty)
//   din      : return address to push
//   top      : current top entry, 0 when empty
//   valid    : stack is non-empty
// Push when full overwrites the oldest entry; push+pop together replace the top.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   sp;      // next free slot; top lives at sp-1
    logic [PW-1:0]   sp_top;
    logic [CW-1:0]   cnt;
    logic            replace;
    logic [PW-1:0]   wr_idx;

    assign sp_top  = sp - PW'(1);
    assign valid   = (cnt != '0);
    assign top     = valid ? mem[sp_top] : '0;
    // A call and return on an empty stack has no top to replace: behaves as a push.
    assign replace = push && pop && valid;
    assign wr_idx  = replace ? sp_top : sp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            cnt <= '0;
        end else if (replace) begin
            sp  <= sp;
            cnt <= cnt;
        end else if (push) begin
            sp <= sp + PW'(1);
            if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
        end else if (pop && valid) begin
            sp  <= sp_top;
            cnt <= cnt - CW'(1);
        end
    end

    // Storage needs no reset: reads are masked by the count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= din;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: Otter fetch-stage program counter.
//   clk, rst : clock, async active-high reset
//   bus      : pc_unit_if.slave -- pc_we/pc_sel/targets/is_call/is_ret in;
//              pc_count/pc_inc/pc_next/pc_valid/misalign/ras_pred/ras_valid out
// Build option: define PC_RAS_EN to instantiate the return-address stack;
// without it RAS_PRED/RAS_VALID read 0 and SEL_RAS behaves as JALR.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter int              INC       = DEF_INC,
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    pc_state_t       state;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            mis_q;
    logic [XLEN-1:0] inc_v;
    logic [XLEN-1:0] jalr_v;
    logic [XLEN-1:0] cand;
    logic            cand_chk;
    logic            mis;
    logic [XLEN-1:0] next_v;
    logic            adv;
    logic [XLEN-1:0] ras_pred;
    logic            ras_valid;

    assign inc_v  = pc_q + INC_V;
    assign jalr_v = {bus.jalr_target[XLEN-1:1], 1'b0};
    assign adv    = (state == ST_RUN) && bus.pc_we;

    always_comb begin
        cand     = inc_v;
        cand_chk = 1'b1;
        case (bus.pc_sel)
            SEL_JALR:   cand = jalr_v;
            SEL_BRANCH: cand = bus.br_target;
            SEL_JAL:    cand = bus.jal_target;
            SEL_TRAP: begin
                cand     = bus.mtvec;
                cand_chk = 1'b0;          // trap vector is trusted as given
            end
            SEL_MRET:   cand = bus.mepc;
            SEL_RAS:    cand = ras_valid ? ras_pred : jalr_v;
            default:    cand = inc_v;
        endcase
    end

    assign mis    = cand_chk && ((cand & ALIGN_MASK) != '0);
    assign next_v = mis ? bus.mtvec : cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_BOOT;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state   <= ST_RUN;
                    valid_q <= 1'b1;
                    mis_q   <= 1'b0;
                end
                ST_RUN: begin
                    // Pulse only on an edge that actually takes the redirect.
                    mis_q <= adv && mis;
                    if (adv) pc_q <= next_v;
                end
                default: begin
                    state   <= ST_BOOT;
                    valid_q <= 1'b0;
                    mis_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (adv && bus.is_call),
        .pop   (adv && bus.is_ret),
        .din   (inc_v),
        .top   (ras_pred),
        .valid (ras_valid)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{bus.is_call, bus.is_ret};
    assign ras_pred   = '0;
    assign ras_valid  = 1'b0;
`endif

    assign bus.pc_count  = pc_q;
    assign bus.pc_inc    = inc_v;
    assign bus.pc_next   = next_v;
    assign bus.pc_valid  = valid_q;
    assign bus.misalign  = mis_q;
    assign bus.ras_pred  = ras_pred;
    assign bus.ras_valid = ras_valid;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit with a queue-based reference model.
// Works in both builds; RAS-specific expectations are enabled with PC_RAS_EN.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int RAS_DEPTH = 4;

    logic clk;
    logic rst;
    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .INC       (4),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ras_on();
`ifdef PC_RAS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_top();
        if (m_ras.size() == 0) return 32'h0;
        return m_ras[m_ras.size()-1];
    endfunction

    // Next address from the selection rules: pick, then redirect if not 4-byte aligned.
    task automatic m_next(input logic [2:0] sel, output logic [31:0] nxt, output bit mis);
        logic [31:0] c;
        logic [31:0] jr;
        jr = bus.jalr_target - (bus.jalr_target % 2);
        case (sel)
            3'd1:    c = jr;
            3'd2:    c = bus.br_target;
            3'd3:    c = bus.jal_target;
            3'd4:    c = bus.mtvec;
            3'd5:    c = bus.mepc;
            3'd6:    c = (m_ras.size() != 0) ? m_top() : jr;
            default: c = m_pc + 32'd4;
        endcase
        mis = (sel != 3'd4) && (c % 4 != 0);
        nxt = mis ? bus.mtvec : c;
    endtask

    task automatic m_reset();
        m_pc   = 32'h0;
        m_boot = 1'b1;
        m_mis  = 1'b0;
        m_ras.delete();
    endtask

    task automatic chk_state();
        chk("pc_count", bus.pc_count, m_pc);
        chk("pc_valid", {31'h0, bus.pc_valid}, {31'h0, !m_boot});
        chk("misalign", {31'h0, bus.misalign}, {31'h0, m_mis});
        chk("ras_valid", {31'h0, bus.ras_valid}, {31'h0, m_ras.size() != 0});
        chk("ras_pred", bus.ras_pred, m_top());
    endtask

    // One clock: drive at posedge+1, check before the next edge, then advance the model.
    task automatic cycle(input bit we, input logic [2:0] sel, input bit call, input bit ret);
        logic [31:0] nxt;
        logic [31:0] inc;
        bit          mis;
        bus.pc_we   = we;
        bus.pc_sel  = pc_sel_t'(sel);
        bus.is_call = call;
        bus.is_ret  = ret;
        #2;
        inc = m_pc + 32'd4;
        m_next(sel, nxt, mis);
        chk_state();
        chk("pc_inc", bus.pc_inc, inc);
        chk("pc_next", bus.pc_next, nxt);
        @(posedge clk);
        #1;
        if (m_boot) begin
            m_boot = 1'b0;
            m_mis  = 1'b0;
        end else begin
            m_mis = we && mis;
            if (we) begin
                m_pc = nxt;
                if (ras_on()) begin
                    if (call && ret && m_ras.size() != 0) begin
                        m_ras[m_ras.size()-1] = inc;
                    end else if (call) begin
                        m_ras.push_back(inc);
                        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                    end else if (ret && m_ras.size() != 0) begin
                        void'(m_ras.pop_back());
                    end
                end
            end
        end
    endtask

    task automatic jump(input logic [31:0] tgt);
        bus.jal_target = tgt;
        cycle(1'b1, 3'd3, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        bus.pc_we       = 1'b0;
        bus.pc_sel      = SEL_SEQ;
        bus.br_target   = '0;
        bus.jal_target  = '0;
        bus.jalr_target = '0;
        bus.mtvec       = 32'h200;
        bus.mepc        = '0;
        bus.is_call     = 1'b0;
        bus.is_ret      = 1'b0;

        // reset and boot
        rst = 1'b1;
        m_reset();
        #3;
        chk_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 3'd0, 1'b0, 1'b0);      // BOOT: PC_WE ignored
        chk("boot_pc0", bus.pc_count, 32'h0);
        cycle(1'b1, 3'd0, 1'b0, 1'b0);
        chk("seq_pc4", bus.pc_count, 32'h4);
        cycle(1'b1, 3'd0, 1'b0, 1'b0);
        chk("seq_pc8", bus.pc_count, 32'h8);

        // stall holds, then JAL loads
        jump(32'h40);
        bus.jal_target = 32'h100;
        repeat (3) cycle(1'b0, 3'd3, 1'b0, 1'b0);
        chk("stall_hold", bus.pc_count, 32'h40);
        cycle(1'b1, 3'd3, 1'b0, 1'b0);
        chk("stall_release", bus.pc_count, 32'h100);

        // misaligned branch redirects to MTVEC with a one-cycle pulse
        bus.br_target = 32'h102;
        bus.mtvec     = 32'h200;
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        chk("mis_pc", bus.pc_count, 32'h200);
        chk("mis_pulse", {31'h0, bus.misalign}, 32'h1);
        cycle(1'b0, 3'd0, 1'b0, 1'b0);
        chk("mis_clear", {31'h0, bus.misalign}, 32'h0);

        // wrap
        jump(32'hFFFF_FFFC);
        cycle(1'b1, 3'd0, 1'b0, 1'b0);
        chk("wrap", bus.pc_count, 32'h0);

        // call/call/return
        jump(32'h10);
        bus.jal_target = 32'h20;
        cycle(1'b1, 3'd3, 1'b1, 1'b0);
        bus.jal_target = 32'h100;
        cycle(1'b1, 3'd3, 1'b1, 1'b0);
`ifdef PC_RAS_EN
        chk("ras_two_calls", bus.ras_pred, 32'h24);
`endif
        bus.jalr_target = 32'h300;
        cycle(1'b1, 3'd6, 1'b0, 1'b1);
`ifdef PC_RAS_EN
        chk("ras_ret_pc", bus.pc_count, 32'h24);
        chk("ras_after_ret", bus.ras_pred, 32'h14);
`else
        chk("ras_off_jalr", bus.pc_count, 32'h300);
`endif
        cycle(1'b1, 3'd6, 1'b0, 1'b1);      // drain remaining entry

        // overflow: five pushes, then five pops
        jump(32'h300);
        repeat (5) cycle(1'b1, 3'd0, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 3'd0, 1'b0, 1'b1);
`ifdef PC_RAS_EN
        chk("ras_oldest_lost", bus.ras_pred, 32'h308);
`endif
        repeat (2) cycle(1'b1, 3'd0, 1'b0, 1'b1);
        chk("ras_empty", {31'h0, bus.ras_valid}, 32'h0);
        bus.jalr_target = 32'h81;
        cycle(1'b1, 3'd6, 1'b0, 1'b0);
        chk("ras_fallback", bus.pc_count, 32'h80);

        // code 7 decodes as SEQ
        cycle(1'b1, 3'd7, 1'b0, 1'b0);
        chk("sel7_seq", bus.pc_count, 32'h84);

        // asynchronous reset mid-cycle
        bus.pc_we = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk_state();
        @(posedge clk);
        #1;
        chk_state();
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.br_target   = rnd_tgt();
            bus.jal_target  = rnd_tgt();
            bus.jalr_target = $urandom;
            bus.mepc        = rnd_tgt();
            bus.mtvec       = $urandom & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
